mem_port_arb4: RTL

- 4-requester round-robin arbiter and sequencer for one shared resource, e.g. the data-memory port in the RISC-V core.
- Its 2-bit select output drives the existing 4:1 select-width mux that steers requester operands (address/wdata/ctrl) onto the shared port.
- Issues a start pulse to the resource and holds the grant until the resource reports completion.
- Returns a completion pulse to the winning requester.

---
 rtl/mem_port_arb_pkg.sv | 22 ++
 rtl/mem_port_arb4_rr_pick.sv | 34 +++
 rtl/mem_port_arb4.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arb_pkg.sv
// Shared types and constants for the 4-requester memory-port arbiter
// (mem_port_arb4 and its rotating-priority picker rr_pick4).
package mem_port_arb_pkg;

    localparam int N_REQ           = 4;
    localparam int SEL_W           = 2;
    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mem_port_arb4_rr_pick.sv
// rr_pick4: combinational rotating-priority search over four requests,
// starting just above the previous winner and wrapping around.
module rr_pick4
    import mem_port_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic             valid,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand [N_REQ];
    logic [N_REQ-1:0] hit;

    // cand[k] is the requester at priority rank k; the 2-bit add wraps mod 4.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign cand[gi] = last + SEL_W'(gi + 1);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        valid = |hit;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
            end
        end
    end

endmodule

// File: rtl/mem_port_arb4.sv
// mem_port_arb4: round-robin arbiter/sequencer for one shared resource port.
// Optional abort-on-timeout in WAIT is enabled with `define MEM_PORT_ARB_TIMEOUT_EN.
module mem_port_arb4 #(
    parameter int N_REQ   = mem_port_arb_pkg::N_REQ,
    parameter int SEL_W   = mem_port_arb_pkg::SEL_W,
    parameter int TIMEOUT = mem_port_arb_pkg::DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             res_done,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] gnt,
    output logic             res_start,
    output logic [N_REQ-1:0] done,
    output logic             busy,
    output logic             err
);
    import mem_port_arb_pkg::*;

    localparam bit CFG_OK = (N_REQ == 4) && (SEL_W == $clog2(N_REQ)) &&
                            (TIMEOUT >= 2) && (TIMEOUT <= 255);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             res_start_q, res_start_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [SEL_W-1:0] last_q, last_d;

    logic             pick_valid;
    logic [SEL_W-1:0] pick_idx;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    rr_pick4 u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        res_start_d = 1'b0;
        done_d      = '0;
        last_d      = last_q;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d     = ISSUE;
                    sel_d       = pick_idx;
                    gnt_d       = idx_to_onehot(pick_idx);
                    res_start_d = 1'b1;
                    last_d      = pick_idx;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            ISSUE: begin
                // A completion arriving while the start pulse is out still counts.
                if (res_done) begin
                    state_d = IDLE;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (res_done) begin
                    state_d = IDLE;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                end
`ifdef MEM_PORT_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LIMIT) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            gnt_q       <= '0;
            res_start_q <= 1'b0;
            done_q      <= '0;
            last_q      <= '1;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            res_start_q <= res_start_d;
            done_q      <= done_d;
            last_q      <= last_d;
        end
    end

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign res_start = res_start_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

    a_cfg_ok:      assert property (@(posedge clk) CFG_OK);
    a_gnt_onehot:  assert property (@(posedge clk) $onehot0(gnt_q));
    a_done_onehot: assert property (@(posedge clk) $onehot0(done_q));
    // The downstream mux must only see sel move at the start of an operation.
    a_sel_stable:  assert property (@(posedge clk)
                       (rst_n && $past(rst_n) && (sel_q != $past(sel_q))) |-> (state_q == ISSUE));

endmodule
